// File: rtl/regfile_dw_pkg.sv
// Shared definitions for the register file: default widths, PC address and
// clear-sequencer state encoding.
package regfile_dw_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    // The PC is never stored; reads of this address return the supplied PC+8.
    localparam logic [ADDR_W_DEF-1:0] PC_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array select, optional write bypass and PC
// substitution for the all-ones address.
module regfile_rdport
    import regfile_dw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = 2**ADDR_W - 1,
    parameter bit BYPASS = 1'b0
) (
    input  state_e                        state_i,
    input  logic [NREGS-1:0][DATA_W-1:0]  rf_i,
    input  logic [ADDR_W-1:0]             ra_i,
    input  logic [DATA_W-1:0]             r15_i,
    input  logic                          we3_i,
    input  logic [ADDR_W-1:0]             wa3_i,
    input  logic [DATA_W-1:0]             wd3_i,
    input  logic                          we4_i,
    input  logic [ADDR_W-1:0]             wa4_i,
    input  logic [DATA_W-1:0]             wd4_i,
    output logic [DATA_W-1:0]             rd_o
);

    localparam logic [ADDR_W-1:0] PcAddr = '1;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_o = '0;
        // Compare against each stored index so the PC address never indexes past the array.
        for (int i = 0; i < NREGS; i++) begin
            if (ra_i == ADDR_W'(i)) rd_o = rf_i[i];
        end
        if (BYPASS && state_i == ST_RUN && ra_i != PcAddr) begin
            if (we3_i && wa3_i == ra_i) rd_o = wd3_i;
            if (we4_i && wa4_i == ra_i) rd_o = wd4_i;
        end
        if (ra_i == PcAddr) rd_o = r15_i;
    end

endmodule

// File: rtl/regfile_dw.sv
// Three-read / two-write register file with PC substitution, optional bypass,
// sticky same-address write conflict flag and a post-reset clear sequencer.
module regfile_dw
    import regfile_dw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = 2**ADDR_W - 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    input  logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic              busy,
    output logic              wr_conflict
);

    localparam logic [ADDR_W-1:0] PcAddr   = '1;
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NREGS - 1);

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            idx_q, idx_d;
    logic                         conflict_q, conflict_d;
    logic [NREGS-1:0][DATA_W-1:0] rf_q;
    logic                         wr3_ok, wr4_ok;

    assign wr3_ok = we3 && state_q == ST_RUN && wa3 != PcAddr;
    assign wr4_ok = we4 && state_q == ST_RUN && wa4 != PcAddr;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            idx_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        conflict_d = conflict_q;
        case (state_q)
            ST_CLEAR: begin
                if (idx_q == LastIdx) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (wr3_ok && wr4_ok && wa3 == wa4) conflict_d = 1'b1;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy        = (state_q == ST_CLEAR);
        wr_conflict = conflict_q;
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (state_q == ST_CLEAR && idx_q == ADDR_W'(i)) begin
                rf_q[i] <= '0;
            end else if (wr4_ok && wa4 == ADDR_W'(i)) begin
                rf_q[i] <= wd4;
            end else if (wr3_ok && wa3 == ADDR_W'(i)) begin
                rf_q[i] <= wd3;
            end
        end
    end

    regfile_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .BYPASS(BYPASS)
    ) u_rd1 (
        .state_i(state_q), .rf_i(rf_q), .ra_i(ra1), .r15_i(r15),
        .we3_i(we3), .wa3_i(wa3), .wd3_i(wd3),
        .we4_i(we4), .wa4_i(wa4), .wd4_i(wd4), .rd_o(rd1)
    );

    regfile_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .BYPASS(BYPASS)
    ) u_rd2 (
        .state_i(state_q), .rf_i(rf_q), .ra_i(ra2), .r15_i(r15),
        .we3_i(we3), .wa3_i(wa3), .wd3_i(wd3),
        .we4_i(we4), .wa4_i(wa4), .wd4_i(wd4), .rd_o(rd2)
    );

    regfile_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .BYPASS(BYPASS)
    ) u_rd3 (
        .state_i(state_q), .rf_i(rf_q), .ra_i(ra3), .r15_i(r15),
        .we3_i(we3), .wa3_i(wa3), .wd3_i(wd3),
        .we4_i(we4), .wa4_i(wa4), .wd4_i(wd4), .rd_o(rd3)
    );

endmodule

// File: tb/tb_regfile_dw.sv
// Bench for regfile_dw: one instance without bypass, one with, checked against
// an array model every cycle plus directed literal expectations.
module tb_regfile_dw;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3, we4;
    logic [3:0]  wa3, wa4, ra1, ra2, ra3;
    logic [31:0] wd3, wd4, r15;
    logic [31:0] rd1_0, rd2_0, rd3_0, rd1_1, rd2_1, rd3_1;
    logic        busy_0, busy_1, conf_0, conf_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_dw #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1_0), .rd2(rd2_0), .rd3(rd3_0), .busy(busy_0), .wr_conflict(conf_0)
    );

    regfile_dw #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
        .rd1(rd1_1), .rd2(rd2_1), .rd3(rd3_1), .busy(busy_1), .wr_conflict(conf_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining clear cycles, stored values and the sticky flag.
    int          clr_left   = 15;
    bit          m_conflict = 1'b0;
    logic [31:0] m_rf [15];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_left   = 15;
            m_conflict = 1'b0;
        end else if (clr_left != 0) begin
            m_rf[15 - clr_left] = 32'h0;
            clr_left--;
        end else begin
            if (we3 && we4 && wa3 == wa4 && wa3 != 4'hF) m_conflict = 1'b1;
            if (we3 && wa3 != 4'hF) m_rf[wa3] = wd3;
            if (we4 && wa4 != 4'hF) m_rf[wa4] = wd4;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
        if (a == 4'hF) return r15;
        if (byp && clr_left == 0) begin
            if (we4 && wa4 == a) return wd4;
            if (we3 && wa3 == a) return wd3;
        end
        return m_rf[a];
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("busy_0", {31'b0, busy_0}, {31'b0, clr_left != 0});
            check("busy_1", {31'b0, busy_1}, {31'b0, clr_left != 0});
            check("conflict_0", {31'b0, conf_0}, {31'b0, m_conflict});
            check("conflict_1", {31'b0, conf_1}, {31'b0, m_conflict});
            if (clr_left == 0) begin
                check("model rd1 nobyp", rd1_0, exp_rd(ra1, 1'b0));
                check("model rd2 nobyp", rd2_0, exp_rd(ra2, 1'b0));
                check("model rd3 nobyp", rd3_0, exp_rd(ra3, 1'b0));
                check("model rd1 byp", rd1_1, exp_rd(ra1, 1'b1));
                check("model rd2 byp", rd2_1, exp_rd(ra2, 1'b1));
                check("model rd3 byp", rd3_1, exp_rd(ra3, 1'b1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we3 = 1'b0; we4 = 1'b0; wa3 = 4'h0; wa4 = 4'h0; wd3 = '0; wd4 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] exp_v;
        logic [31:0] r15_vals [3];

        reset = 1'b0;
        idle_writes();
        ra1 = 4'h0; ra2 = 4'h0; ra3 = 4'h0;
        r15 = 32'h0000_1008;
        repeat (3) tick();
        check("reset busy", {31'b0, busy_0}, 32'd1);
        check("reset conflict", {31'b0, conf_0}, 32'd0);
        reset = 1'b1;

        // Clear sequence length.
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_0) n++;
            else break;
        end
        check("clear busy cycles", n, 32'd15);

        // Every stored entry is zero, the PC address returns r15.
        for (int a = 0; a < 16; a++) begin
            tick();
            ra1 = 4'(a); ra2 = 4'(a); ra3 = 4'(a);
            @(negedge clk);
            exp_v = (a == 15) ? 32'h0000_1008 : 32'h0;
            check("cleared rd1", rd1_0, exp_v);
            check("cleared rd3 byp", rd3_1, exp_v);
        end

        // Dual write to distinct addresses.
        tick();
        we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hDEAD_BEEF;
        we4 = 1'b1; wa4 = 4'd3; wd4 = 32'h1234_5678;
        tick();
        idle_writes();
        ra1 = 4'd2; ra2 = 4'd3;
        @(negedge clk);
        check("dual rd1", rd1_0, 32'hDEAD_BEEF);
        check("dual rd2", rd2_0, 32'h1234_5678);
        check("dual no conflict", {31'b0, conf_0}, 32'd0);

        // Same-address conflict: port 4 wins, flag is sticky.
        tick();
        we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h1;
        we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h2;
        tick();
        idle_writes();
        ra1 = 4'd5;
        @(negedge clk);
        check("conflict rd1", rd1_0, 32'h2);
        check("conflict flag", {31'b0, conf_0}, 32'd1);
        repeat (10) tick();
        @(negedge clk);
        check("conflict sticky", {31'b0, conf_1}, 32'd1);

        // PC address: write dropped, reads follow r15.
        tick();
        we3 = 1'b1; wa3 = 4'hF; wd3 = 32'hFFFF_FFFF;
        ra3 = 4'hF; r15 = 32'hAAAA_0000;
        @(negedge clk);
        check("pc rd3 during write", rd3_1, 32'hAAAA_0000);
        tick();
        idle_writes();
        r15_vals[0] = 32'h0000_1008;
        r15_vals[1] = 32'hFFFF_FFFF;
        r15_vals[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            r15 = r15_vals[k];
            @(negedge clk);
            check("pc rd3", rd3_0, r15_vals[k]);
        end
        for (int a = 0; a < 15; a++) begin
            tick();
            ra1 = 4'(a);
            @(negedge clk);
            case (a)
                2:       exp_v = 32'hDEAD_BEEF;
                3:       exp_v = 32'h1234_5678;
                5:       exp_v = 32'h2;
                default: exp_v = 32'h0;
            endcase
            check("array after pc write", rd1_0, exp_v);
        end

        // Bypass versus registered read.
        tick();
        we3 = 1'b1; wa3 = 4'd7; wd3 = 32'hA5A5_A5A5; ra1 = 4'd7;
        @(negedge clk);
        check("bypass rd1", rd1_1, 32'hA5A5_A5A5);
        check("no bypass rd1", rd1_0, 32'h0);
        tick();
        idle_writes();
        @(negedge clk);
        check("after edge rd1", rd1_0, 32'hA5A5_A5A5);
        tick();
        we3 = 1'b1; wa3 = 4'd8; wd3 = 32'h1;
        we4 = 1'b1; wa4 = 4'd8; wd4 = 32'h88;
        ra2 = 4'd8;
        @(negedge clk);
        check("bypass port4 priority", rd2_1, 32'h88);
        check("no bypass port4", rd2_0, 32'h0);
        tick();
        idle_writes();
        @(negedge clk);
        check("port4 stored", rd2_0, 32'h88);

        // Reset mid-clear, then writes issued while busy are dropped.
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (6) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_0) n++;
            else break;
            tick();
            if (n == 10) begin
                we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h4444;
                we4 = 1'b1; wa4 = 4'd4; wd4 = 32'h5555;
            end else if (n == 12) begin
                idle_writes();
            end
        end
        check("reclear busy cycles", n, 32'd15);
        check("busy write no conflict", {31'b0, conf_0}, 32'd0);
        tick();
        ra1 = 4'd4; ra2 = 4'd7;
        @(negedge clk);
        check("busy write dropped", rd1_0, 32'h0);
        check("reclear zeroed", rd2_1, 32'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dw.md
Name: regfile_dw

Overview:
- Parametrised successor of the processor's register file for the multicycle ARM-style datapath.
- Provides three combinational read ports. The third port feeds the MLA/UMLAL accumulate operands.
- Provides two independent write ports: port 3 carries the result or low word; port 4 carries the long-multiply high word.
- Provides optional write-to-read bypass, an R15 (PC) read substitution, and a post-reset clear sequencer that zeroes the array one entry per cycle while asserting busy.
- Sits between the decode/control unit and the ALU/multiplier in the datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 4: register address width. The highest address (all ones) is the PC and is not stored.
- NREGS, 2**ADDR_W-1: number of stored registers, 15.
- BYPASS, 0: when 1, a read of an address being written this cycle returns the write data.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- we3, input, 1: write enable, port 3.
- wa3, input, ADDR_W: write address, port 3.
- wd3, input, DATA_W: write data, port 3.
- we4, input, 1: write enable, port 4 (long-multiply high word). Independent of we3.
- wa4, input, ADDR_W: write address, port 4.
- wd4, input, DATA_W: write data, port 4.
- ra1, ra2, ra3, input, ADDR_W each: read addresses.
- r15, input, DATA_W: PC+8 value returned for reads of address all-ones.
- rd1, rd2, rd3, output, DATA_W each: read data.
- busy, output, 1: clear sequence in progress. Writes are ignored while high.
- wr_conflict, output, 1: sticky flag, set when both ports write the same address in one cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR, clear index = 0.
  - busy=1, wr_conflict=0.
  - Array contents are not reset directly.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes zero to rf[idx] and increments idx.
  - When idx==NREGS-1, that entry is zeroed and the FSM moves to RUN on the same edge.
  - busy deasserts in the following cycle. Clear takes exactly NREGS cycles after reset release.
  - RUN: normal operation. There is no exit except reset.
- Reset mid-clear: asynchronously restarts at idx 0.
- Reads (combinational, all three ports identical):
  - Address all-ones returns r15.
  - Otherwise returns rf[addr].
  - Reads during CLEAR return current array contents, which may be unzeroed. Consumers must wait for busy=0.
- Writes (RUN only):
  - On the rising edge, rf[wa3] <= wd3 if we3, and rf[wa4] <= wd4 if we4.
  - Writes to address all-ones are dropped silently.
- Same-address conflict (we3 && we4 && wa3==wa4, address not all-ones):
  - Port 4 wins.
  - wr_conflict goes to 1 on that edge and holds until reset.
- Bypass (BYPASS=1, RUN only):
  - A read whose address matches an active write this cycle returns that write's data. Port 4 takes priority if both match.
  - Address all-ones is never bypassed.
- Bypass (BYPASS=0): reads return the pre-edge contents. The new value is visible the cycle after the edge.
- Write latency: 1 edge.
- Read latency: 0 (combinational).
- Writes asserted while busy=1: dropped. No conflict is flagged.

Decomposition:
- Shared package holds:
  - the PC address constant (all ones of ADDR_W);
  - FSM state encoding for CLEAR and RUN;
  - a default DATA_W constant shared with the ALU and multiplier.
- Natural sub-module: regfile_rdport, one combinational read mux handling the PC substitution and bypass. It is instantiated three times.
- Clear FSM and storage stay in the top module.

Test Plan:
- Clear sequence:
  - Release reset.
  - busy=1 for exactly 15 cycles, then 0.
  - Reading every address 0..14 returns 0.
  - Address 15 returns r15=0x0000_1008.
- Dual write:
  - In RUN, drive we3=1, wa3=2, wd3=0xDEADBEEF and we4=1, wa4=3, wd4=0x12345678.
  - Next cycle: ra1=2 reads 0xDEADBEEF, ra2=3 reads 0x12345678. wr_conflict stays 0.
- Conflict:
  - Write wa3=wa4=5 with wd3=0x1, wd4=0x2.
  - rd1(ra1=5) reads 0x2 the next cycle.
  - wr_conflict=1, and still 1 after 10 idle cycles.
- PC port:
  - Write wa3=15, wd3=0xFFFF_FFFF, then vary r15.
  - rd3(ra3=15) always equals r15. rf contents are unchanged (check all 15 entries).
- Bypass:
  - With BYPASS=1, write wa3=7, wd3=0xA5A5A5A5 and read ra1=7 in the same cycle: rd1=0xA5A5A5A5 before the edge.
  - With BYPASS=0, the same stimulus gives the old value.
- Reset mid-clear and writes during busy:
  - Assert reset at clear cycle 6; after release, busy lasts 15 cycles again.
  - A we3 write to address 4 issued while busy is dropped: address 4 reads 0 after the clear.
